// File: rtl/adder_nbit_pipelined.sv
// ----------------------------------------------------------------------------
// adder_nbit_pipelined
//
// N-bit adder with carry-in, built as a carry-chain pipeline. Each stage holds
// one CHUNK_BITS-wide ripple slice. Stage k adds chunk k using the carry
// registered by stage k-1. Operand chunks that are still to be added travel
// forward in skew registers. Sum chunks that are already done travel forward
// in deskew registers. A valid/ready handshake sits on both sides. One global
// advance signal stalls the whole pipeline, so throughput is one result per
// cycle when the consumer keeps up.
//
// Parameters:
//   NUM_BITS   - operand and sum width (must be a multiple of CHUNK_BITS)
//   CHUNK_BITS - width of one ripple slice; STAGES = NUM_BITS / CHUNK_BITS
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - a, b, carry_in and mode are valid
//   in_ready     - block accepts an input this cycle (= advance)
//   a, b         - operands
//   carry_in     - carry into bit 0
//   mode         - 0: unsigned overflow, 1: signed overflow
//   out_valid    - out_sum / out_overflow hold a result
//   out_ready    - consumer takes the result this cycle
//   out_sum      - (a + b + carry_in) mod 2^NUM_BITS
//   out_overflow - overflow flag for the mode captured with the transaction
// ----------------------------------------------------------------------------
module adder_nbit_pipelined #(
    parameter int unsigned NUM_BITS   = 16,
    parameter int unsigned CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_sum,
    output logic                out_overflow
);

    localparam int unsigned STAGES = NUM_BITS / CHUNK_BITS;

    if ((NUM_BITS % CHUNK_BITS) != 0) begin : g_param_check
        $error("adder_nbit_pipelined: NUM_BITS must be a multiple of CHUNK_BITS");
    end

    // Result word of one slice: {carry out, carry into slice MSB, sum bits}.
    localparam int unsigned SliceW = CHUNK_BITS + 2;

    // Stage registers. Index k holds the transaction that has finished chunk k.
    logic [STAGES-1:0]   v_q;
    logic [STAGES-1:0]   m_q;
    logic [STAGES-1:0]   c_q;
    logic [NUM_BITS-1:0] a_q [STAGES];
    logic [NUM_BITS-1:0] b_q [STAGES];
    logic [NUM_BITS-1:0] s_q [STAGES];
    logic                ovf_q;

    // Inputs seen by each stage: the ports for stage 0, the previous stage otherwise.
    logic [STAGES-1:0]   v_src;
    logic [STAGES-1:0]   m_src;
    logic [STAGES-1:0]   c_src;
    logic [NUM_BITS-1:0] a_src [STAGES];
    logic [NUM_BITS-1:0] b_src [STAGES];
    logic [NUM_BITS-1:0] s_src [STAGES];

    // Per-stage slice results.
    logic [SliceW-1:0]   slice_res [STAGES];
    logic [NUM_BITS-1:0] s_nxt [STAGES];
    logic [STAGES-1:0]   c_nxt;
    logic [STAGES-1:0]   c_top;
    logic                ovf_nxt;

    logic                advance;

    // Plain bit-serial ripple over one chunk. It also returns the carry into the
    // chunk MSB, which the signed overflow rule needs at the top slice.
    function automatic logic [SliceW-1:0] ripple_slice(
        input logic [CHUNK_BITS-1:0] x,
        input logic [CHUNK_BITS-1:0] y,
        input logic                  cin
    );
        logic [CHUNK_BITS-1:0] s;
        logic                  c;
        logic                  c_msb;
        s     = '0;
        c     = cin;
        c_msb = cin;
        for (int i = 0; i < CHUNK_BITS; i++) begin
            c_msb = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_msb, s};
    endfunction

    // Global stall: nothing moves while a result is waiting for the consumer.
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    assign out_valid    = v_q[STAGES-1];
    assign out_sum      = s_q[STAGES-1];
    assign out_overflow = ovf_q;

    always_comb begin
        v_src = '0;
        m_src = '0;
        c_src = '0;
        a_src = '{default: '0};
        b_src = '{default: '0};
        s_src = '{default: '0};

        v_src[0] = in_valid;
        m_src[0] = mode;
        c_src[0] = carry_in;
        a_src[0] = a;
        b_src[0] = b;
        s_src[0] = '0;

        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
            m_src[k] = m_q[k-1];
            c_src[k] = c_q[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
        end
    end

    always_comb begin
        slice_res = '{default: '0};
        s_nxt     = '{default: '0};
        c_nxt     = '0;
        c_top     = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = ripple_slice(a_src[k][k*CHUNK_BITS +: CHUNK_BITS],
                                        b_src[k][k*CHUNK_BITS +: CHUNK_BITS],
                                        c_src[k]);
            s_nxt[k]                              = s_src[k];
            s_nxt[k][k*CHUNK_BITS +: CHUNK_BITS]  = slice_res[k][CHUNK_BITS-1:0];
            c_top[k]                              = slice_res[k][CHUNK_BITS];
            c_nxt[k]                              = slice_res[k][CHUNK_BITS+1];
        end
        // The top slice finishes the word, so the flag is resolved here and
        // registered alongside the final sum.
        ovf_nxt = m_src[STAGES-1] ? (c_top[STAGES-1] ^ c_nxt[STAGES-1])
                                  : c_nxt[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            m_q   <= '0;
            c_q   <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q   <= v_src;
            m_q   <= m_src;
            c_q   <= c_nxt;
            a_q   <= a_src;
            b_q   <= b_src;
            s_q   <= s_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // The last stage's skew/mode/carry copies and the lower slices' MSB carries
    // have no reader. Operand bits below the current chunk also die downstream.
    // Synthesis trims all of these.
    logic unused_tail;
    assign unused_tail = ^{m_q[STAGES-1], c_q[STAGES-1], a_q[STAGES-1], b_q[STAGES-1], c_top};

endmodule

// File: tb/tb_adder_nbit_pipelined.sv
module tb_adder_nbit_pipelined;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 16-bit, 4 stages
    logic        vin16, rdy16, ov16, ordy16, cin16, m16, ovf16;
    logic [15:0] a16, b16, sum16;
    // Two 8-bit variants sharing one stimulus
    logic        vin8, ordy8, cin8, m8;
    logic [7:0]  a8, b8;
    logic        ir_a, ov_a, ovf_a, ir_b, ov_b, ovf_b;
    logic [7:0]  sum_a, sum_b;

    exp_t q16[$];
    exp_t q8a[$];
    exp_t q8b[$];

    int total = 0;
    int bad   = 0;
    int run16 = 0;
    int max_run16 = 0;

    logic [7:0] bvals [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    adder_nbit_pipelined u_dut16 (
        .clk(clk), .rst(rst), .in_valid(vin16), .in_ready(rdy16), .a(a16), .b(b16),
        .carry_in(cin16), .mode(m16), .out_valid(ov16), .out_ready(ordy16),
        .out_sum(sum16), .out_overflow(ovf16)
    );

    adder_nbit_pipelined #(.NUM_BITS(8), .CHUNK_BITS(2)) u_dut8c2 (
        .clk(clk), .rst(rst), .in_valid(vin8), .in_ready(ir_a), .a(a8), .b(b8),
        .carry_in(cin8), .mode(m8), .out_valid(ov_a), .out_ready(ordy8),
        .out_sum(sum_a), .out_overflow(ovf_a)
    );

    adder_nbit_pipelined #(.NUM_BITS(8), .CHUNK_BITS(8)) u_dut8c8 (
        .clk(clk), .rst(rst), .in_valid(vin8), .in_ready(ir_b), .a(a8), .b(b8),
        .carry_in(cin8), .mode(m8), .out_valid(ov_b), .out_ready(ordy8),
        .out_sum(sum_b), .out_overflow(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        return e;
    endfunction

    // Reference: wide add for the unsigned flag, sign comparison for the signed flag.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci, input logic mi);
        logic [16:0] full;
        logic [15:0] mask;
        logic        sa, sb, ss;
        exp_t        e;
        mask  = 16'((17'h1 << w) - 17'h1);
        full  = {1'b0, av & mask} + {1'b0, bv & mask} + {16'h0, ci};
        e.sum = full[15:0] & mask;
        sa    = av[w-1];
        sb    = bv[w-1];
        ss    = e.sum[w-1];
        e.ovf = mi ? ((sa == sb) && (ss != sa)) : full[w];
        return e;
    endfunction

    // Monitors: pop and compare whenever a result is handed over.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (ov16) run16++;
            else run16 = 0;
            if (run16 > max_run16) max_run16 = run16;
            if (ov16 && ordy16) begin
                if (q16.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dut16 unexpected result: got sum=%0h want no output", sum16);
                end else begin
                    e = q16.pop_front();
                    chk("dut16 sum", 32'(sum16), 32'(e.sum));
                    chk("dut16 ovf", 32'(ovf16), 32'(e.ovf));
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ov_a && ordy8) begin
            if (q8a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut8c2 unexpected result: got sum=%0h want no output", sum_a);
            end else begin
                e = q8a.pop_front();
                chk("dut8c2 sum", 32'(sum_a), 32'(e.sum));
                chk("dut8c2 ovf", 32'(ovf_a), 32'(e.ovf));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ov_b && ordy8) begin
            if (q8b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut8c8 unexpected result: got sum=%0h want no output", sum_b);
            end else begin
                e = q8b.pop_front();
                chk("dut8c8 sum", 32'(sum_b), 32'(e.sum));
                chk("dut8c8 ovf", 32'(ovf_b), 32'(e.ovf));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic mi, input exp_t e);
        bit done = 0;
        a16 = av; b16 = bv; cin16 = ci; m16 = mi; vin16 = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (rdy16) begin
                q16.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        vin16 = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send16 timeout: got no acceptance want accept within 100 cycles");
        end
    endtask

    // Drives both 8-bit variants; in_valid is raised only when both accept.
    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic mi);
        bit   done = 0;
        exp_t e;
        e  = model(8, {8'h0, av}, {8'h0, bv}, ci, mi);
        a8 = av; b8 = bv; cin8 = ci; m8 = mi;
        for (int n = 0; n < 100 && !done; n++) begin
            ordy8 = ($urandom_range(0, 3) != 0);
            #1;
            vin8 = ir_a && ir_b;
            @(negedge clk);
            if (vin8) begin
                q8a.push_back(e);
                q8b.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        vin8 = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send8 timeout: got no acceptance want accept within 100 cycles");
        end
    endtask

    task automatic drain16();
        for (int n = 0; n < 100 && q16.size() != 0; n++) @(posedge clk);
        #1;
        chk("dut16 results pending after drain", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        int         lat;
        int         cnt;
        bit         found;
        logic [15:0] hs;
        logic        ho;

        vin16 = 0; a16 = 0; b16 = 0; cin16 = 0; m16 = 0; ordy16 = 1;
        vin8 = 0; a8 = 0; b8 = 0; cin8 = 0; m8 = 0; ordy8 = 1;

        // Reset state, visible before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset out_valid", 32'(ov16), 32'd0);
        chk("reset out_sum", 32'(sum16), 32'd0);
        chk("reset out_overflow", 32'(ovf16), 32'd0);
        chk("reset in_ready", 32'(rdy16), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Carry chain through every slice, plus first-result latency
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1));
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            if (ov16) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("latency edges after accept", 32'(lat), 32'd3);
        drain16();
        @(posedge clk); #1;
        send16(16'hFFFF, 16'h0001, 1'b1, 1'b0, mk(16'h0001, 1'b1));

        // Signed/unsigned overflow cases, back to back
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b0));
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0));
        send16(16'h8000, 16'h8000, 1'b0, 1'b1, mk(16'h0000, 1'b1));
        send16(16'h7FFF, 16'h0000, 1'b1, 1'b1, mk(16'h8000, 1'b1));
        send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1));
        send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, mk(16'hFFFF, 1'b0));
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b1));
        drain16();
        @(posedge clk); #1;

        // Asynchronous reset with three transactions in flight
        send16(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0));
        send16(16'hF000, 16'h2000, 1'b1, 1'b0, mk(16'h1001, 1'b1));
        send16(16'h4000, 16'h4000, 1'b0, 1'b1, mk(16'h8000, 1'b1));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrun reset out_valid", 32'(ov16), 32'd0);
        chk("midrun reset out_sum", 32'(sum16), 32'd0);
        chk("midrun reset out_overflow", 32'(ovf16), 32'd0);
        chk("midrun reset in_ready", 32'(rdy16), 32'd1);
        q16.delete();
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ov16) cnt++;
        end
        chk("stale results after reset", 32'(cnt), 32'd0);
        @(posedge clk); #1;

        // Streaming, mode toggling every transaction
        max_run16 = 0;
        for (int i = 0; i < 10; i++) begin
            logic [15:0] av, bv;
            logic        ci, mi;
            av = 16'(16'h1357 * (i + 1));
            bv = 16'hF0F0 ^ 16'(16'h0111 * i);
            ci = (i % 3 == 0);
            mi = i[0];
            send16(av, bv, ci, mi, model(16, av, bv, ci, mi));
        end
        drain16();
        chk("stream consecutive valid cycles", 32'(max_run16), 32'd10);
        @(posedge clk); #1;

        // Backpressure: three stalled edges mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] av, bv;
                    logic        ci, mi;
                    av = 16'(16'h2345 * i);
                    bv = 16'(16'hFEDC - i);
                    ci = i[1];
                    mi = i[0];
                    send16(av, bv, ci, mi, model(16, av, bv, ci, mi));
                end
            end
            begin
                found = 0;
                for (int n = 0; n < 30; n++) begin
                    @(negedge clk);
                    if (ov16) begin
                        found = 1;
                        break;
                    end
                end
                chk("bp output seen", 32'(found), 32'd1);
                @(posedge clk); #2;
                ordy16 = 1'b0;
                hs = sum16;
                ho = ovf16;
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    chk("bp in_ready low", 32'(rdy16), 32'd0);
                    chk("bp out_valid held", 32'(ov16), 32'd1);
                    chk("bp out_sum held", 32'(sum16), 32'(hs));
                    chk("bp out_overflow held", 32'(ovf16), 32'(ho));
                end
                @(posedge clk); #2;
                ordy16 = 1'b1;
            end
        join
        drain16();

        // Sweep on both 8-bit variants with random consumer stalls
        @(posedge clk); #1;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int cm = 0; cm < 4; cm++) begin
                    send8(8'(ai), bvals[bi], cm[0], cm[1]);
                end
            end
        end
        ordy8 = 1'b1;
        for (int n = 0; n < 100 && (q8a.size() != 0 || q8b.size() != 0); n++) @(posedge clk);
        #1;
        chk("dut8c2 results pending after drain", 32'(q8a.size()), 32'd0);
        chk("dut8c8 results pending after drain", 32'(q8b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
